serial_io_buffer: RTL and testbench
===================================

Name: serial_io_buffer

Overview:
- Byte-wide buffering stage between the processor's serial port and the external host/test side.
- RX FIFO (host -> processor) drives the processor's serial_in / serial_valid_in and is drained by serial_rden_out.
- TX FIFO (processor -> host) is filled by serial_out / serial_wren_out and throttled by serial_ready_in.
- Decouples processor instruction timing from host byte timing.

Parameters:
- DEPTH, 16, entries per FIFO; power of two, minimum 2.
- ADDR_W, 4, log2(DEPTH); pointer width.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset asserted.
- proc_rd_data  out  8  RX head byte; drives processor serial_in.
- proc_rd_valid  out  1  RX FIFO non-empty; drives serial_valid_in.
- proc_rden  in  1  pop RX head; from serial_rden_out.
- proc_wr_data  in  8  byte from processor serial_out.
- proc_wren  in  1  push byte into TX FIFO; from serial_wren_out.
- proc_wr_ready  out  1  TX FIFO not full; drives serial_ready_in.
- host_rx_data  in  8  byte from host.
- host_rx_valid  in  1  host byte offered.
- host_rx_ready  out  1  RX FIFO not full.
- host_tx_data  out  8  TX head byte to host.
- host_tx_valid  out  1  TX FIFO non-empty.
- host_tx_ready  in  1  host accepts TX head.
- rx_count  out  ADDR_W+1  RX occupancy, 0..DEPTH.
- tx_count  out  ADDR_W+1  TX occupancy, 0..DEPTH.
- rd_underflow  out  1  sticky: proc_rden seen while RX empty.
- wr_overflow  out  1  sticky: proc_wren seen while TX full.
- clear_flags  in  1  synchronous clear of both sticky flags.

Behaviour:
Reset (reset=0, asynchronous, any time including mid-transfer):
- Both FIFOs emptied; pointers and counts go to 0.
- proc_rd_valid=0, host_tx_valid=0, host_rx_ready=1, proc_wr_ready=1.
- proc_rd_data=0 and host_tx_data=0; rd_underflow=0 and wr_overflow=0.
- Stored contents are discarded. Operation resumes on the first rising edge after reset returns to 1.

FIFO organisation:
- Two independent, identical circular FIFOs.
- Write/read pointers are ADDR_W bits and wrap from DEPTH-1 to 0.
- Occupancy is held in a registered count of ADDR_W+1 bits.
- Full: count==DEPTH. Empty: count==0.
- All ready/valid outputs decode from registered counts only; there is no combinational path from inputs.

Data presentation (first-word-fall-through):
- proc_rd_data and host_tx_data show the head entry whenever the matching valid is 1.
- When valid is 0, these outputs hold their last value.

Handshakes:
- RX push: host_rx_valid & host_rx_ready at the edge.
- RX pop: proc_rden & proc_rd_valid.
- TX push: proc_wren & proc_wr_ready.
- TX pop: host_tx_valid & host_tx_ready.
- A valid held with ready=0 has no effect. Host-side data must stay stable until accepted.

Latency:
- Byte pushed into an empty FIFO at edge N: valid=1 and data visible after edge N, so it can be popped at edge N+1.
- Pop at edge N exposes the next entry after edge N.

Simultaneous events:
- Push and pop in the same edge on a non-empty, non-full FIFO: count unchanged, both pointers advance.
- Full FIFO with a pop this cycle: ready is already 0, so the push is not taken (no bypass).
- Empty FIFO with a push this cycle: the pop is invalid (valid=0), so it is treated as underflow.

Error flags:
- proc_rden=1 while proc_rd_valid=0: no state change except rd_underflow<=1.
- proc_wren=1 while proc_wr_ready=0: byte dropped, wr_overflow<=1.
- clear_flags=1 clears both flags. If clear and a new error occur in the same edge, the flag is set (set wins).

Host side:
- The host side never raises error flags; its violations are impossible by protocol.

Counts:
- rx_count and tx_count are registered and update on the same edge as the push/pop.
- They never exceed DEPTH and never go below 0.

Test Plan:
1. Reset, then host pushes 0xAA: rx_count=1, proc_rd_valid=1, proc_rd_data=0xAA one cycle after push. proc_rden for 1 cycle then gives rx_count=0, proc_rd_valid=0.
2. Processor writes 0x48,0x69 on consecutive cycles with host_tx_ready=0: tx_count=2. Raise host_tx_ready: host_tx_data=0x48 then 0x69 on consecutive cycles, then host_tx_valid=0.
3. Push 16 bytes 0x00..0x0F into RX: host_rx_ready=0 at count 16; a 17th offer is not accepted. Pops return 0x00..0x0F in order across pointer wrap.
4. TX full (16) and proc_wren with 0x55: byte dropped, wr_overflow=1, tx_count stays 16. clear_flags gives wr_overflow=0.
5. RX at count 5 with simultaneous host push and proc_rden for 10 cycles: rx_count stays 5 and output order is preserved. proc_rden on empty RX sets rd_underflow=1.
6. Assert reset=0 mid-stream with rx_count=7, tx_count=3: counts go to 0 immediately without a clock edge, valids go to 0, readies go to 1, flags go to 0.

Source files
------------

// File: rtl/serial_io_buffer.sv
// rtl/serial_io_buffer.sv - byte FIFOs between processor serial port and host side
module sib_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [7:0]        wdata_i,
  input  logic              pop_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [7:0]        rdata_o,
  output logic [ADDR_W:0]   count_o
);
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
  logic [ADDR_W:0]   count_q, count_d;
  logic [7:0]        head_q, head_d;
  logic              push_ok, pop_ok;

  assign ready_o = (count_q != FULL_CNT);
  assign valid_o = (count_q != '0);
  assign rdata_o = head_q;
  assign count_o = count_q;

  always_comb begin
    push_ok  = push_i & ready_o;
    pop_ok   = pop_i & valid_o;
    rd_nxt   = rd_ptr_q + PTR_ONE;
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_nxt : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop_ok) count_d = count_q + CNT_ONE;
    if (pop_ok && !push_ok) count_d = count_q - CNT_ONE;
    // Head register: next entry comes from memory, or straight from the push
    // when the FIFO is (or becomes) holding only the new byte.
    head_d = head_q;
    if (push_ok && count_q == '0) begin
      head_d = wdata_i;
    end else if (pop_ok) begin
      if (count_q == CNT_ONE) begin
        if (push_ok) head_d = wdata_i;
      end else begin
        head_d = mem_q[rd_nxt];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end
endmodule

module serial_io_buffer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  output logic [7:0]        proc_rd_data,
  output logic              proc_rd_valid,
  input  logic              proc_rden,
  input  logic [7:0]        proc_wr_data,
  input  logic              proc_wren,
  output logic              proc_wr_ready,
  input  logic [7:0]        host_rx_data,
  input  logic              host_rx_valid,
  output logic              host_rx_ready,
  output logic [7:0]        host_tx_data,
  output logic              host_tx_valid,
  input  logic              host_tx_ready,
  output logic [ADDR_W:0]   rx_count,
  output logic [ADDR_W:0]   tx_count,
  output logic              rd_underflow,
  output logic              wr_overflow,
  input  logic              clear_flags
);
  logic rd_underflow_q, rd_underflow_d, wr_overflow_q, wr_overflow_d;

  sib_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rx (
    .clk(clock), .rst_n(reset),
    .push_i(host_rx_valid), .wdata_i(host_rx_data), .pop_i(proc_rden),
    .ready_o(host_rx_ready), .valid_o(proc_rd_valid), .rdata_o(proc_rd_data),
    .count_o(rx_count)
  );

  sib_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_tx (
    .clk(clock), .rst_n(reset),
    .push_i(proc_wren), .wdata_i(proc_wr_data), .pop_i(host_tx_ready),
    .ready_o(proc_wr_ready), .valid_o(host_tx_valid), .rdata_o(host_tx_data),
    .count_o(tx_count)
  );

  // A new error in the same cycle as clear_flags leaves the flag set.
  always_comb begin
    rd_underflow_d = clear_flags ? 1'b0 : rd_underflow_q;
    wr_overflow_d  = clear_flags ? 1'b0 : wr_overflow_q;
    if (proc_rden && !proc_rd_valid) rd_underflow_d = 1'b1;
    if (proc_wren && !proc_wr_ready) wr_overflow_d  = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_underflow_q <= 1'b0;
      wr_overflow_q  <= 1'b0;
    end else begin
      rd_underflow_q <= rd_underflow_d;
      wr_overflow_q  <= wr_overflow_d;
    end
  end

  assign rd_underflow = rd_underflow_q;
  assign wr_overflow  = wr_overflow_q;
endmodule

// File: tb/tb_serial_io_buffer.sv
// tb/tb_serial_io_buffer.sv - directed vector bench for serial_io_buffer
module tb_serial_io_buffer;
  logic       clock, reset;
  logic [7:0] proc_rd_data, proc_wr_data, host_rx_data, host_tx_data;
  logic       proc_rd_valid, proc_rden, proc_wren, proc_wr_ready;
  logic       host_rx_valid, host_rx_ready, host_tx_valid, host_tx_ready;
  logic [4:0] rx_count, tx_count;
  logic       rd_underflow, wr_overflow, clear_flags;

  int total = 0;
  int bad   = 0;

  serial_io_buffer dut (
    .clock(clock), .reset(reset),
    .proc_rd_data(proc_rd_data), .proc_rd_valid(proc_rd_valid), .proc_rden(proc_rden),
    .proc_wr_data(proc_wr_data), .proc_wren(proc_wren), .proc_wr_ready(proc_wr_ready),
    .host_rx_data(host_rx_data), .host_rx_valid(host_rx_valid), .host_rx_ready(host_rx_ready),
    .host_tx_data(host_tx_data), .host_tx_valid(host_tx_valid), .host_tx_ready(host_tx_ready),
    .rx_count(rx_count), .tx_count(tx_count),
    .rd_underflow(rd_underflow), .wr_overflow(wr_overflow), .clear_flags(clear_flags)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       hv;  logic [7:0] hd;  logic rden;
    logic       wren; logic [7:0] wd; logic txr; logic clr;
    logic [4:0] e_rxc; logic e_rdv; logic [7:0] e_rdd;
    logic [4:0] e_txc; logic e_txv; logic [7:0] e_txd;
    logic       e_uf;  logic e_of;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    host_rx_valid = 0; host_rx_data = 8'h00; proc_rden = 0;
    proc_wren = 0; proc_wr_data = 8'h00; host_tx_ready = 0; clear_flags = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // hv hd rden wren wd txr clr | rxc rdv rdd txc txv txd uf of
    vecs[0]  = '{1, 8'hAA, 0, 0, 8'h00, 0, 0, 1, 1, 8'hAA, 0, 0, 8'h00, 0, 0};
    vecs[1]  = '{0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 8'hAA, 0, 0, 8'h00, 0, 0};
    vecs[2]  = '{0, 8'h00, 0, 1, 8'h48, 0, 0, 0, 0, 8'hAA, 1, 1, 8'h48, 0, 0};
    vecs[3]  = '{0, 8'h00, 0, 1, 8'h69, 0, 0, 0, 0, 8'hAA, 2, 1, 8'h48, 0, 0};
    vecs[4]  = '{0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 8'hAA, 1, 1, 8'h69, 0, 0};
    vecs[5]  = '{0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 8'hAA, 0, 0, 8'h69, 0, 0};
    vecs[6]  = '{0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 8'hAA, 0, 0, 8'h69, 1, 0};
    vecs[7]  = '{0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 8'hAA, 0, 0, 8'h69, 0, 0};
    vecs[8]  = '{0, 8'h00, 1, 0, 8'h00, 0, 1, 0, 0, 8'hAA, 0, 0, 8'h69, 1, 0};
    vecs[9]  = '{0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 8'hAA, 0, 0, 8'h69, 0, 0};
    vecs[10] = '{1, 8'h3C, 1, 0, 8'h00, 0, 0, 1, 1, 8'h3C, 0, 0, 8'h69, 1, 0};
    vecs[11] = '{0, 8'h00, 1, 0, 8'h00, 0, 1, 0, 0, 8'h3C, 0, 0, 8'h69, 0, 0};
    vecs[12] = '{0, 8'h00, 0, 1, 8'h11, 0, 0, 0, 0, 8'h3C, 1, 1, 8'h11, 0, 0};
    vecs[13] = '{0, 8'h00, 0, 1, 8'h22, 1, 0, 0, 0, 8'h3C, 1, 1, 8'h22, 0, 0};
    vecs[14] = '{0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 8'h3C, 0, 0, 8'h22, 0, 0};

    idle();
    reset = 0;
    #12;
    chk("rst_rx_count", rx_count, 0);
    chk("rst_tx_count", tx_count, 0);
    chk("rst_rd_valid", proc_rd_valid, 0);
    chk("rst_tx_valid", host_tx_valid, 0);
    chk("rst_rx_ready", host_rx_ready, 1);
    chk("rst_wr_ready", proc_wr_ready, 1);
    chk("rst_rd_data", proc_rd_data, 0);
    chk("rst_tx_data", host_tx_data, 0);
    chk("rst_flags", {rd_underflow, wr_overflow}, 0);
    @(negedge clock);
    reset = 1;
    tick();

    for (int i = 0; i < 15; i++) begin
      host_rx_valid = vecs[i].hv;   host_rx_data = vecs[i].hd; proc_rden = vecs[i].rden;
      proc_wren = vecs[i].wren;     proc_wr_data = vecs[i].wd; host_tx_ready = vecs[i].txr;
      clear_flags = vecs[i].clr;
      tick();
      chk($sformatf("v%0d_rx_count", i), rx_count, vecs[i].e_rxc);
      chk($sformatf("v%0d_rd_valid", i), proc_rd_valid, vecs[i].e_rdv);
      chk($sformatf("v%0d_rd_data", i), proc_rd_data, vecs[i].e_rdd);
      chk($sformatf("v%0d_tx_count", i), tx_count, vecs[i].e_txc);
      chk($sformatf("v%0d_tx_valid", i), host_tx_valid, vecs[i].e_txv);
      chk($sformatf("v%0d_tx_data", i), host_tx_data, vecs[i].e_txd);
      chk($sformatf("v%0d_underflow", i), rd_underflow, vecs[i].e_uf);
      chk($sformatf("v%0d_overflow", i), wr_overflow, vecs[i].e_of);
    end
    idle();

    // RX fill to full, rejected 17th offer, drain across pointer wrap
    for (int i = 0; i < 16; i++) begin
      host_rx_valid = 1; host_rx_data = 8'(i);
      tick();
    end
    chk("rxfull_count", rx_count, 16);
    chk("rxfull_ready", host_rx_ready, 0);
    host_rx_data = 8'h99;
    tick();
    chk("rx17_count", rx_count, 16);
    host_rx_valid = 0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("rxdrain%0d_data", i), proc_rd_data, 8'(i));
      proc_rden = 1;
      tick();
    end
    proc_rden = 0;
    chk("rxdrain_count", rx_count, 0);
    chk("rxdrain_valid", proc_rd_valid, 0);
    chk("rxdrain_ready", host_rx_ready, 1);

    // TX full, overflow drop, flag clear, drain order intact
    for (int i = 0; i < 16; i++) begin
      proc_wren = 1; proc_wr_data = 8'(8'h20 + i);
      tick();
    end
    chk("txfull_count", tx_count, 16);
    chk("txfull_ready", proc_wr_ready, 0);
    proc_wr_data = 8'h55;
    tick();
    proc_wren = 0;
    chk("ovf_flag", wr_overflow, 1);
    chk("ovf_count", tx_count, 16);
    clear_flags = 1;
    tick();
    clear_flags = 0;
    chk("ovf_clear", wr_overflow, 0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("txdrain%0d_data", i), host_tx_data, 8'(8'h20 + i));
      host_tx_ready = 1;
      tick();
    end
    host_tx_ready = 0;
    chk("txdrain_valid", host_tx_valid, 0);

    // RX held at 5 with concurrent push and pop
    for (int i = 0; i < 5; i++) begin
      host_rx_valid = 1; host_rx_data = 8'(8'h40 + i);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("pp%0d_head", i), proc_rd_data, (i < 5) ? 8'(8'h40 + i) : 8'(8'h50 + i - 5));
      host_rx_valid = 1; host_rx_data = 8'(8'h50 + i); proc_rden = 1;
      tick();
      chk($sformatf("pp%0d_count", i), rx_count, 5);
    end
    host_rx_valid = 0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("pptail%0d_data", i), proc_rd_data, 8'(8'h55 + i));
      tick();
    end
    chk("pp_empty", rx_count, 0);
    tick();
    proc_rden = 0;
    chk("uf_set", rd_underflow, 1);

    // Async reset mid-stream
    for (int i = 0; i < 7; i++) begin
      host_rx_valid = 1; host_rx_data = 8'(8'h70 + i);
      proc_wren = (i < 3); proc_wr_data = 8'(8'h30 + i);
      tick();
    end
    idle();
    chk("pre_rst_rx", rx_count, 7);
    chk("pre_rst_tx", tx_count, 3);
    @(negedge clock);
    #2;
    reset = 0;
    #1;
    chk("arst_rx_count", rx_count, 0);
    chk("arst_tx_count", tx_count, 0);
    chk("arst_valids", {proc_rd_valid, host_tx_valid}, 0);
    chk("arst_readies", {host_rx_ready, proc_wr_ready}, 2'b11);
    chk("arst_flags", {rd_underflow, wr_overflow}, 0);
    chk("arst_data", {proc_rd_data, host_tx_data}, 0);
    @(negedge clock);
    reset = 1;
    host_rx_valid = 1; host_rx_data = 8'hC3;
    tick();
    idle();
    chk("post_rst_count", rx_count, 1);
    chk("post_rst_data", proc_rd_data, 8'hC3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
